// File: rtl/mic1_out_uart_reporter.sv
// UART hex reporter for the MIC-1 output word.
// Sends the 32-bit word as eight uppercase hex digits followed by CR LF (8N1),
// whenever the word differs from the last one sent or a resend is requested.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | waiting for a changed word or a resend request
// S_START | start bit of the current character
// S_DATA  | eight data bits, LSB first
// S_STOP  | stop bit, then next character or back to idle
module mic1_out_uart_reporter #(
  parameter int CLKS_PER_BIT = 52
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] word_in,
  input  logic        en,
  input  logic        force_send,
  output logic        tx,
  output logic        busy
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(CLKS_PER_BIT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [31:0]   snap_q, snap_d;
  logic [31:0]   last_sent_q, last_sent_d;
  logic          pending_q, pending_d;
  logic [3:0]    char_idx_q, char_idx_d;
  logic [TW-1:0] bit_tmr_q, bit_tmr_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;

  logic          trigger;
  logic          bit_done;
  logic [2:0]    nib_sel;
  logic [3:0]    nibble;
  logic [7:0]    cur_char;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) hex_ascii = 8'h30 + {4'h0, n};
    else           hex_ascii = 8'h37 + {4'h0, n};
  endfunction

  assign trigger  = (state_q == S_IDLE) && en &&
                    ((word_in != last_sent_q) || force_send || pending_q);
  assign bit_done = (bit_tmr_q == TMR_LAST);

  // Character currently on the wire: digit index 0 is the top nibble.
  always_comb begin
    nib_sel = 3'd7 - char_idx_q[2:0];
    nibble  = snap_q[{nib_sel, 2'b00} +: 4];
    case (char_idx_q)
      4'd8:    cur_char = 8'h0D;
      4'd9:    cur_char = 8'h0A;
      default: cur_char = hex_ascii(nibble);
    endcase
  end

  // Next-state logic for the frame sequencer, timers and resend flag.
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    last_sent_d = last_sent_q;
    pending_d   = pending_q;
    char_idx_d  = char_idx_q;
    bit_tmr_d   = bit_tmr_q;
    bit_cnt_d   = bit_cnt_q;

    if (state_q != S_IDLE) begin
      bit_tmr_d = bit_done ? '0 : bit_tmr_q + TW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (trigger) begin
          snap_d      = word_in;
          last_sent_d = word_in;
          char_idx_d  = 4'd0;
          bit_tmr_d   = '0;
          bit_cnt_d   = 3'd0;
          state_d     = S_START;
        end
      end
      S_START: begin
        if (bit_done) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_done) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_STOP;
        end
      end
      default: begin
        if (bit_done) begin
          if (char_idx_q == 4'd9) begin
            state_d = S_IDLE;
          end else begin
            char_idx_d = char_idx_q + 4'd1;
            state_d    = S_START;
          end
        end
      end
    endcase

    // A request that coincides with the trigger is consumed by that frame.
    if (trigger)         pending_d = 1'b0;
    else if (force_send) pending_d = 1'b1;
  end

  // Output drive is derived from the registered state, one cycle behind it,
  // so tx and busy have no combinational path from any input.
  always_comb begin
    case (state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_char[bit_cnt_q];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_q != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      snap_q      <= 32'h0;
      last_sent_q <= 32'h0;
      pending_q   <= 1'b0;
      char_idx_q  <= 4'd0;
      bit_tmr_q   <= '0;
      bit_cnt_q   <= 3'd0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      last_sent_q <= last_sent_d;
      pending_q   <= pending_d;
      char_idx_q  <= char_idx_d;
      bit_tmr_q   <= bit_tmr_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mic1_out_uart_reporter.sv
// Bench for mic1_out_uart_reporter at CLKS_PER_BIT = 4.
// Stimulus pushes expected bytes; a UART decoder pops and compares them.
module tb_mic1_out_uart_reporter;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] word_in;
  logic        en;
  logic        force_send;
  logic        tx;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int frames   = 0;
  logic [7:0] exp_q[$];

  mic1_out_uart_reporter #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .word_in    (word_in),
    .en         (en),
    .force_send (force_send),
    .tx         (tx),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== lvl && n < budget);
    chk(busy === lvl, name, 32'(n), 32'(budget));
  endtask

  // Counts negedges until tx is seen low; called right after an input change.
  task automatic start_lat(input string name, input int exp_n);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tx === 1'b1 && n < 20);
    chk(n == exp_n, name, 32'(n), 32'(exp_n));
  endtask

  task automatic idle_quiet(input int cycles, input string name);
    int bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk(bad == 0, name, 32'(bad), 32'd0);
  endtask

  // UART decoder / scoreboard monitor; bytes cut short by reset are dropped.
  initial begin
    logic [7:0] b;
    logic       stop_b;
    bit         ab;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && tx === 1'b0) begin
        ab = 1'b0;
        repeat (2) @(negedge clk);
        if (resetn !== 1'b1) ab = 1'b1;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
          if (resetn !== 1'b1) ab = 1'b1;
        end
        repeat (CPB) @(negedge clk);
        stop_b = tx;
        if (resetn !== 1'b1) ab = 1'b1;
        if (!ab) begin
          chk(stop_b === 1'b1, "stop_bit", 32'(stop_b), 32'd1);
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_byte", 32'(b), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk(b === e, "rx_byte", 32'(b), 32'(e));
          end
        end
      end
    end
  end

  // Every frame that is not cut by reset keeps busy high for 100*CPB cycles.
  initial begin
    int len = 0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        if (len == 0) frames++;
        len++;
      end else if (len > 0) begin
        if (resetn === 1'b1) chk(len == 100 * CPB, "busy_len", 32'(len), 32'(100 * CPB));
        len = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn     = 1'b0;
    word_in    = 32'h0;
    en         = 1'b1;
    force_send = 1'b0;
    repeat (3) @(negedge clk);
    chk(tx === 1'b1, "rst_tx", 32'(tx), 32'd1);
    chk(busy === 1'b0, "rst_busy", 32'(busy), 32'd0);
    tick();
    resetn = 1'b1;
    idle_quiet(1000, "zero_word_idle");

    // Changed word: one frame, start bit two edges after the change.
    tick();
    word_in = 32'h0000_00A5;
    push_str("000000A5");
    start_lat("a5_latency", 3);
    repeat (50) tick();
    word_in = 32'h1;
    repeat (50) tick();
    word_in = 32'h2;
    repeat (50) tick();
    word_in = 32'hDEAD_BEEF;
    push_str("DEADBEEF");
    wait_busy(1'b0, 400, "a5_end");
    start_lat("followup_gap", 1);
    wait_busy(1'b0, 410, "beef_end");
    repeat (600) tick();
    chk(frames == 2, "frames_after_change", 32'(frames), 32'd2);

    // Resend of an unchanged word; three pulses mid-frame collapse into one.
    tick();
    force_send = 1'b1;
    push_str("DEADBEEF");
    tick();
    force_send = 1'b0;
    wait_busy(1'b1, 10, "force_start");
    repeat (30) tick();
    for (int i = 0; i < 3; i++) begin
      force_send = 1'b1;
      tick();
      force_send = 1'b0;
      repeat (20) tick();
    end
    push_str("DEADBEEF");
    wait_busy(1'b0, 400, "force1_end");
    wait_busy(1'b1, 10, "force2_start");
    wait_busy(1'b0, 410, "force2_end");
    repeat (600) tick();
    chk(frames == 4, "frames_after_force", 32'(frames), 32'd4);

    // Enable gating.
    tick();
    en = 1'b0;
    word_in = 32'h0000_0010;
    idle_quiet(600, "en_low_hold");
    tick();
    en = 1'b1;
    push_str("00000010");
    start_lat("en_latency", 3);
    wait_busy(1'b0, 410, "en_frame_end");
    repeat (20) tick();

    // Reset in the data bits of char 3, then a fresh frame of the same word.
    force_send = 1'b1;
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h30);
    tick();
    force_send = 1'b0;
    wait_busy(1'b1, 10, "rst_frame_start");
    repeat (130) tick();
    resetn = 1'b0;
    #1;
    chk(tx === 1'b1, "async_rst_tx", 32'(tx), 32'd1);
    chk(busy === 1'b0, "async_rst_busy", 32'(busy), 32'd0);
    repeat (40) tick();
    push_str("00000010");
    resetn = 1'b1;
    start_lat("post_rst_latency", 3);
    wait_busy(1'b0, 410, "post_rst_end");
    repeat (100) tick();
    chk(exp_q.size() == 0, "leftover_bytes", 32'(exp_q.size()), 32'd0);
    chk(frames == 7, "frames_total", 32'(frames), 32'd7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
